// File: rtl/simple_pkg.sv
// simple_pkg: shared encodings for the SIMPLE core EX->MEM stage.
//  Provides the memory-op encoding, the OUT opcode and the 7-segment encoder.
//  seg_encode maps a hex nibble to active-high segments {a,b,c,d,e,f,g,dp}.
package simple_pkg;

   typedef enum logic [1:0] {
      MEM_NONE  = 2'd0,
      MEM_READ  = 2'd1,
      MEM_WRITE = 2'd2,
      MEM_RSVD  = 2'd3
   } mem_op_e;

   localparam logic [3:0] OP_OUT = 4'b1101;

   localparam logic [7:0] SEG_LUT [16] = '{
      8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
      8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E
   };

   function automatic logic [7:0] seg_encode(input logic [3:0] nib);
      return SEG_LUT[nib];
   endfunction

endpackage

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexes a NUM_DIGITS-nibble value onto a 7-segment bank.
//  Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   disp_on_i        display enable (next-state of the owner's register)
//   disp_val_i       value to show, nibble NUM_DIGITS-1 is the leftmost digit
//   seg_o            registered active-high segments of the selected digit
//   digit_sel_o      registered one-hot digit select, MSB = most significant nibble
//  seg_o/digit_sel_o are computed from the next-state index and display value so
//  they always describe the digit and value held in the registers this cycle.
module seg_scan
   import simple_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    disp_on_i,
   input  logic [4*NUM_DIGITS-1:0] disp_val_i,
   output logic [7:0]              seg_o,
   output logic [NUM_DIGITS-1:0]   digit_sel_o
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

   logic [CW-1:0]         cnt_q, cnt_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [NUM_DIGITS-1:0] sel_d;
   logic [3:0]            nib_d;
   logic [7:0]            seg_d;
   logic                  wrap;

   assign wrap = cnt_q == CW'(SCAN_DIV - 1);

   always_comb begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      idx_d = !wrap ? idx_q : idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1;
      sel_d = '0;
      nib_d = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         sel_d[k] = idx_d == IW'(NUM_DIGITS - 1 - k);
         if (sel_d[k]) nib_d = disp_val_i[4*k +: 4];
      end
      seg_d = disp_on_i ? seg_encode(nib_d) : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q                   <= '0;
         idx_q                   <= '0;
         seg_o                   <= 8'h00;
         digit_sel_o             <= '0;
         digit_sel_o[NUM_DIGITS-1] <= 1'b1;
      end else begin
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         seg_o       <= seg_d;
         digit_sel_o <= sel_d;
      end
   end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register with valid/ready, flush and OUT display.
//  Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid/in_ready           upstream handshake (in_ready combinational)
//   flush                       kills held and incoming instruction
//   in_opcode, in_op_a          opcode and OUT operand
//   in_alu_result/_flags        execute results
//   in_mem_op                   0 none, 1 read, 2 write, 3 none
//   in_wr_reg, in_reg_addr      writeback control
//   in_addr, in_store_data      memory address and store data
//   out_valid/out_ready         downstream handshake
//   out_*                       registered payload; enables gated by out_valid
//   seg, digit_sel              scanned 7-segment display of the last OUT value
//  Optional macro EX_MEM_PERF_CNT_EN adds saturating stall_cnt and out_cnt ports.
module ex_mem_stage
   import simple_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 3,
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  flush,
   input  logic [3:0]            in_opcode,
   input  logic [DATA_W-1:0]     in_op_a,
   input  logic [DATA_W-1:0]     in_alu_result,
   input  logic [3:0]            in_alu_flags,
   input  logic [1:0]            in_mem_op,
   input  logic                  in_wr_reg,
   input  logic [REG_ADDR_W-1:0] in_reg_addr,
   input  logic [DATA_W-1:0]     in_addr,
   input  logic [DATA_W-1:0]     in_store_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_alu_result,
   output logic [3:0]            out_alu_flags,
   output logic [REG_ADDR_W-1:0] out_reg_addr,
   output logic [DATA_W-1:0]     out_addr,
   output logic [DATA_W-1:0]     out_store_data,
   output logic                  out_wr_reg,
   output logic                  out_rd_en,
   output logic                  out_wr_en,
   output logic [7:0]            seg,
   output logic [NUM_DIGITS-1:0] digit_sel
`ifdef EX_MEM_PERF_CNT_EN
   ,
   output logic [15:0]           stall_cnt,
   output logic [15:0]           out_cnt
`endif
);

   localparam int DW = 4 * NUM_DIGITS;

   logic                  valid_q, valid_d;
   logic [DATA_W-1:0]     res_q, res_d;
   logic [3:0]            flags_q, flags_d;
   logic [REG_ADDR_W-1:0] reg_q, reg_d;
   logic [DATA_W-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic                  wr_reg_q, wr_reg_d;
   logic                  rd_q, rd_d;
   logic                  wr_q, wr_d;
   logic [DW-1:0]         disp_val_q, disp_val_d;
   logic                  disp_on_q, disp_on_d;
   logic                  accept, is_out;

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready && !flush;
   assign is_out   = accept && in_opcode == OP_OUT;

   // When nothing is held, out_ready alone clearing valid is equivalent to a drain.
   always_comb begin
      valid_d    = flush ? 1'b0 : accept ? 1'b1 : out_ready ? 1'b0 : valid_q;
      res_d      = accept ? in_alu_result : res_q;
      flags_d    = accept ? in_alu_flags : flags_q;
      reg_d      = accept ? in_reg_addr : reg_q;
      addr_d     = accept ? in_addr : addr_q;
      data_d     = accept ? in_store_data : data_q;
      wr_reg_d   = accept ? in_wr_reg : wr_reg_q;
      rd_d       = accept ? in_mem_op == MEM_READ : rd_q;
      wr_d       = accept ? in_mem_op == MEM_WRITE : wr_q;
      disp_val_d = is_out ? in_op_a[DW-1:0] : disp_val_q;
      disp_on_d  = is_out || disp_on_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         res_q      <= '0;
         flags_q    <= '0;
         reg_q      <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         wr_reg_q   <= 1'b0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         disp_val_q <= '0;
         disp_on_q  <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         res_q      <= res_d;
         flags_q    <= flags_d;
         reg_q      <= reg_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         wr_reg_q   <= wr_reg_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         disp_val_q <= disp_val_d;
         disp_on_q  <= disp_on_d;
      end
   end

   assign out_valid      = valid_q;
   assign out_alu_result = res_q;
   assign out_alu_flags  = flags_q;
   assign out_reg_addr   = reg_q;
   assign out_addr       = addr_q;
   assign out_store_data = data_q;
   assign out_wr_reg     = wr_reg_q && valid_q;
   assign out_rd_en      = rd_q && valid_q;
   assign out_wr_en      = wr_q && valid_q;

   // The scanner registers seg from next-state display values so a new OUT
   // value appears on the same edge that latches it.
   seg_scan #(
      .NUM_DIGITS (NUM_DIGITS),
      .SCAN_DIV   (SCAN_DIV)
   ) u_scan (
      .clk         (clk),
      .rst_n       (rst_n),
      .disp_on_i   (disp_on_d),
      .disp_val_i  (disp_val_d),
      .seg_o       (seg),
      .digit_sel_o (digit_sel)
   );

`ifdef EX_MEM_PERF_CNT_EN
   logic [15:0] stall_q, stall_d;
   logic [15:0] ocnt_q, ocnt_d;

   always_comb begin
      stall_d = valid_q && !out_ready && stall_q != 16'hFFFF ? stall_q + 1'b1 : stall_q;
      ocnt_d  = is_out && ocnt_q != 16'hFFFF ? ocnt_q + 1'b1 : ocnt_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_q <= '0;
         ocnt_q  <= '0;
      end else begin
         stall_q <= stall_d;
         ocnt_q  <= ocnt_d;
      end
   end

   assign stall_cnt = stall_q;
   assign out_cnt   = ocnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed and randomized checks of ex_mem_stage against a transaction-level model.
module tb_ex_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, flush, out_ready, in_wr_reg;
   logic [3:0]  in_opcode, in_alu_flags;
   logic [15:0] in_op_a, in_alu_result, in_addr, in_store_data;
   logic [1:0]  in_mem_op;
   logic [2:0]  in_reg_addr;
   logic        in_ready, out_valid, out_wr_reg, out_rd_en, out_wr_en;
   logic [15:0] out_alu_result, out_addr, out_store_data;
   logic [3:0]  out_alu_flags, digit_sel;
   logic [2:0]  out_reg_addr;
   logic [7:0]  seg;
`ifdef EX_MEM_PERF_CNT_EN
   logic [15:0] stall_cnt, out_cnt;
`endif

   always #5 clk = ~clk;

   ex_mem_stage #(.DATA_W(16), .REG_ADDR_W(3), .NUM_DIGITS(4), .SCAN_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .in_opcode(in_opcode), .in_op_a(in_op_a), .in_alu_result(in_alu_result),
      .in_alu_flags(in_alu_flags), .in_mem_op(in_mem_op), .in_wr_reg(in_wr_reg),
      .in_reg_addr(in_reg_addr), .in_addr(in_addr), .in_store_data(in_store_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_alu_result(out_alu_result),
      .out_alu_flags(out_alu_flags), .out_reg_addr(out_reg_addr), .out_addr(out_addr),
      .out_store_data(out_store_data), .out_wr_reg(out_wr_reg), .out_rd_en(out_rd_en),
      .out_wr_en(out_wr_en), .seg(seg), .digit_sel(digit_sel)
`ifdef EX_MEM_PERF_CNT_EN
      , .stall_cnt(stall_cnt), .out_cnt(out_cnt)
`endif
   );

   logic [7:0] seg_tbl [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h1A, 8'h7A, 8'h9E, 8'h8E};

   int nchk = 0, nfail = 0;

   // Model: the held transaction, the last displayed value, and cycles since reset.
   logic        m_valid, m_wr_reg, m_rd, m_wr, m_on;
   logic [15:0] m_res, m_addr, m_data, m_disp;
   logic [3:0]  m_flags;
   logic [2:0]  m_reg;
   int          ticks, m_stall, m_ocnt;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic acc;
      if (!rst_n) begin
         {m_valid, m_wr_reg, m_rd, m_wr, m_on} = '0;
         {m_res, m_addr, m_data, m_disp, m_flags, m_reg} = '0;
         ticks = 0; m_stall = 0; m_ocnt = 0;
      end else begin
         acc = in_valid && (!m_valid || out_ready) && !flush;
         if (m_valid && !out_ready && m_stall < 65535) m_stall++;
         if (acc && in_opcode == 4'hD && m_ocnt < 65535) m_ocnt++;
         if (flush) m_valid = 0;
         else if (acc) begin
            m_valid = 1; m_res = in_alu_result; m_flags = in_alu_flags; m_reg = in_reg_addr;
            m_addr = in_addr; m_data = in_store_data; m_wr_reg = in_wr_reg;
            m_rd = in_mem_op == 2'd1; m_wr = in_mem_op == 2'd2;
         end else if (m_valid && out_ready) m_valid = 0;
         if (acc && in_opcode == 4'hD) begin
            m_disp = in_op_a; m_on = 1;
         end
         ticks++;
      end
   endtask

   task automatic check_outs();
      int idx;
      logic [3:0] nib;
      idx = (ticks / 4) % 4;
      nib = 4'((m_disp >> (4 * (3 - idx))) & 16'hF);
      chk("out_valid", out_valid, m_valid);
      chk("alu_result", out_alu_result, m_res);
      chk("alu_flags", out_alu_flags, m_flags);
      chk("reg_addr", out_reg_addr, m_reg);
      chk("addr", out_addr, m_addr);
      chk("store_data", out_store_data, m_data);
      chk("wr_reg", out_wr_reg, m_wr_reg && m_valid);
      chk("rd_en", out_rd_en, m_rd && m_valid);
      chk("wr_en", out_wr_en, m_wr && m_valid);
      chk("seg", seg, m_on ? seg_tbl[nib] : 8'h00);
      chk("digit_sel", digit_sel, 4'b1000 >> idx);
`ifdef EX_MEM_PERF_CNT_EN
      chk("stall_cnt", stall_cnt, m_stall);
      chk("out_cnt", out_cnt, m_ocnt);
`endif
   endtask

   task automatic cycle();
      #1;
      chk("in_ready", in_ready, !m_valid || out_ready);
      @(posedge clk);
      model_edge();
      #1;
      check_outs();
   endtask

   task automatic idle();
      in_valid = 0; flush = 0; out_ready = 1; in_opcode = 0; in_op_a = 0; in_alu_result = 0;
      in_alu_flags = 0; in_mem_op = 0; in_wr_reg = 0; in_reg_addr = 0; in_addr = 0; in_store_data = 0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      @(posedge clk);
      model_edge();
      #1;
      check_outs();
      rst_n = 1;
   endtask

   initial begin
      idle();
      do_reset();
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_digit_sel", digit_sel, 4'b1000);
      // store accepted with latency 1
      in_valid = 1; in_mem_op = 2; in_addr = 16'h0010; in_store_data = 16'hBEEF;
      in_alu_result = 16'h1111; in_wr_reg = 1; in_reg_addr = 3'd5; in_alu_flags = 4'hA;
      cycle();
      chk("t1_wr_en", out_wr_en, 1'b1);
      chk("t1_rd_en", out_rd_en, 1'b0);
      chk("t1_data", out_store_data, 16'hBEEF);
      // stall with a pending load, then drain and accept on the same edge
      in_mem_op = 1; in_addr = 16'h0020; in_wr_reg = 0;
      cycle();
      out_ready = 0; in_addr = 16'h0030;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("t2_in_ready", in_ready, 1'b0);
         chk("t2_frozen", out_addr, 16'h0020);
      end
      out_ready = 1;
      cycle();
      chk("t2_next_addr", out_addr, 16'h0030);
      chk("t2_rd_en", out_rd_en, 1'b1);
      // flushed OUT must not reach the display
      flush = 1; in_opcode = 4'hD; in_op_a = 16'h1234;
      cycle();
      chk("t3_valid", out_valid, 1'b0);
      chk("t3_seg", seg, 8'h00);
      // OUT display scan from a known phase
      idle();
      do_reset();
      in_valid = 1; in_opcode = 4'hD; in_op_a = 16'h1234;
      cycle();
      idle();
      chk("t4_seg_d3", seg, 8'h60);
      chk("t4_sel_d3", digit_sel, 4'b1000);
      repeat (3) cycle();
      chk("t4_seg_d2", seg, 8'hDA);
      chk("t4_sel_d2", digit_sel, 4'b0100);
      repeat (4) cycle();
      chk("t4_seg_d1", seg, 8'hF2);
      chk("t4_sel_d1", digit_sel, 4'b0010);
      repeat (4) cycle();
      chk("t4_seg_d0", seg, 8'h66);
      chk("t4_sel_d0", digit_sel, 4'b0001);
      repeat (4) cycle();
      chk("t4_seg_wrap", seg, 8'h60);
      chk("t4_sel_wrap", digit_sel, 4'b1000);
      // reset in the middle of a stall
      in_valid = 1; in_alu_result = 16'h5A5A;
      cycle();
      out_ready = 0;
      repeat (2) cycle();
      rst_n = 0;
      cycle();
      rst_n = 1;
      chk("t5_valid", out_valid, 1'b0);
      chk("t5_in_ready", in_ready, 1'b1);
      chk("t5_seg", seg, 8'h00);
      chk("t5_result", out_alu_result, 16'h0000);
`ifdef EX_MEM_PERF_CNT_EN
      idle();
      do_reset();
      in_valid = 1; out_ready = 0;
      repeat (6) cycle();
      out_ready = 1; in_opcode = 4'hD; in_op_a = 16'h0042;
      repeat (2) cycle();
      chk("t6_stall_cnt", stall_cnt, 16'd5);
      chk("t6_out_cnt", out_cnt, 16'd2);
`endif
      // randomized traffic
      idle();
      for (int i = 0; i < 600; i++) begin
         rst_n         = $urandom_range(0, 79) != 0;
         in_valid      = $urandom_range(0, 9) < 7;
         out_ready     = $urandom_range(0, 9) < 6;
         flush         = $urandom_range(0, 9) == 0;
         in_opcode     = $urandom_range(0, 2) == 0 ? 4'hD : 4'($urandom);
         in_op_a       = 16'($urandom);
         in_alu_result = 16'($urandom);
         in_alu_flags  = 4'($urandom);
         in_mem_op     = 2'($urandom);
         in_wr_reg     = 1'($urandom);
         in_reg_addr   = 3'($urandom);
         in_addr       = 16'($urandom);
         in_store_data = 16'($urandom);
         cycle();
      end
      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule
